// File: rtl/alu_pkg.sv
// Shared definitions for the MIPS-style ALU.
//   WIDTH_DEFAULT : default operand/result width.
//   OP_*          : 4-bit operation select codes.
`timescale 1ns/1ps
package alu_pkg;

  localparam int WIDTH_DEFAULT = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOR = 4'b0101;
  localparam logic [3:0] OP_SLT = 4'b1011;

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit adder/subtractor shared by ADD, SUB and SLT.
//   a, b : operands
//   sub  : 1 -> a + ~b + 1 (a - b), 0 -> a + b
//   sum  : result modulo 2^WIDTH (carry-out discarded)
//   ovf  : signed two's-complement overflow of the operation performed
`timescale 1ns/1ps
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;

  // Subtraction reuses the adder: invert B and inject the +1 as carry-in.
  assign b_eff = sub ? ~b : b;
  assign sum   = a + b_eff + WIDTH'(sub);

  // Overflow when both adder inputs share a sign that the sum does not.
  // With b inverted this is the usual "signs differ" rule for subtraction.
  assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu.sv
// 32-bit combinational ALU with a registered copy of its outputs.
//   clk, rst_n     : clock and async active-low reset (registered outputs only)
//   A, B           : operands
//   op             : operation select (see alu_pkg OP_*)
//   RES, ZERO, OVF : combinational result, zero flag, signed overflow (ADD/SUB)
//   RES_Q, ZERO_Q, OVF_Q : the above, registered on the rising clk edge
`timescale 1ns/1ps
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] RES,
  output logic             ZERO,
  output logic             OVF,
  output logic [WIDTH-1:0] RES_Q,
  output logic             ZERO_Q,
  output logic             OVF_Q
);

  logic             as_sub;
  logic [WIDTH-1:0] as_sum;
  logic             as_ovf;
  logic             signed_lt;

  // SLT needs A - B, so it shares the subtract path with SUB.
  assign as_sub = (op == OP_SUB) || (op == OP_SLT);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a   (A),
    .b   (B),
    .sub (as_sub),
    .sum (as_sum),
    .ovf (as_ovf)
  );

  // Correcting the difference sign by the overflow keeps the signed
  // comparison right even when A - B wraps (e.g. 0x80000000 vs 0x7FFFFFFF).
  assign signed_lt = as_sum[WIDTH-1] ^ as_ovf;

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch and
    // unused opcodes resolve to a clean zero instead of X.
    RES = '0;
    OVF = 1'b0;
    case (op)
      OP_AND: RES = A & B;
      OP_OR:  RES = A | B;
      OP_XOR: RES = A ^ B;
      OP_NOR: RES = ~(A | B);
      OP_ADD: begin
        RES = as_sum;
        OVF = as_ovf;
      end
      OP_SUB: begin
        RES = as_sum;
        OVF = as_ovf;
      end
      OP_SLT: RES = {{(WIDTH-1){1'b0}}, signed_lt};
      default: RES = '0;
    endcase
  end

  assign ZERO = (RES == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments; the async reset
    // clears only these three output registers, never the combinational path.
    if (!rst_n) begin
      RES_Q  <= '0;
      ZERO_Q <= 1'b0;
      OVF_Q  <= 1'b0;
    end else begin
      RES_Q  <= RES;
      ZERO_Q <= ZERO;
      OVF_Q  <= OVF;
    end
  end

endmodule

// File: tb/tb_alu.sv
`timescale 1ns/1ps
module tb_alu;
  import alu_pkg::*;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] A, B;
  logic [3:0]  op;
  logic [31:0] RES, RES_Q;
  logic        ZERO, OVF, ZERO_Q, OVF_Q;

  int n_vec = 0;
  int n_err = 0;

  alu #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .op     (op),
    .RES    (RES),
    .ZERO   (ZERO),
    .OVF    (OVF),
    .RES_Q  (RES_Q),
    .ZERO_Q (ZERO_Q),
    .OVF_Q  (OVF_Q)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic apply(input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b);
    op = o;
    A  = a;
    B  = b;
  endtask

  // Independent reference: 64-bit signed arithmetic for overflow and SLT.
  function automatic void model(input logic [3:0] o, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic v);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 32'h0;
    v  = 1'b0;
    case (o)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      OP_ADD: begin
        s = sa + sb;
        r = a + b;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SUB: begin
        s = sa - sb;
        r = a - b;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      OP_SLT: r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = 32'h0;
    endcase
  endfunction

  vec_t        vecs[$];
  logic [3:0]  ops[7];
  logic [31:0] exp_r;
  logic        exp_v;

  initial begin
    vecs.push_back('{OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0});
    vecs.push_back('{OP_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0});
    vecs.push_back('{OP_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0});
    vecs.push_back('{OP_NOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0});
    vecs.push_back('{OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1});
    vecs.push_back('{OP_ADD, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1});
    vecs.push_back('{OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1});
    vecs.push_back('{OP_SUB, 32'h00000000, 32'h80000000, 32'h80000000, 1'b0, 1'b1});
    vecs.push_back('{OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{OP_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{OP_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{OP_SLT, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{4'b0011, 32'h00001234, 32'h00005678, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{4'b0110, 32'h00001234, 32'h00005678, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{4'b1111, 32'h00001234, 32'h00005678, 32'h00000000, 1'b1, 1'b0});

    ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_NOR, OP_SLT};

    // ---- reset state and registered path ----
    rst_n = 1'b1;
    apply(OP_ADD, 32'd2, 32'd3);
    #5 rst_n = 1'b0;
    #5;
    check("reset RES_Q", RES_Q, 32'h0);
    check("reset ZERO_Q", {31'b0, ZERO_Q}, 32'h0);
    check("reset OVF_Q", {31'b0, OVF_Q}, 32'h0);

    // A clock edge while reset is held must not load.
    @(posedge clk); #1;
    check("held reset RES_Q", RES_Q, 32'h0);

    // First edge after release loads 2+3.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reg ADD RES_Q", RES_Q, 32'd5);
    check("reg ADD ZERO_Q", {31'b0, ZERO_Q}, 32'h0);
    check("reg ADD OVF_Q", {31'b0, OVF_Q}, 32'h0);

    @(negedge clk);
    apply(OP_ADD, 32'h7FFFFFFF, 32'h1);
    @(posedge clk); #1;
    check("reg OVF RES_Q", RES_Q, 32'h80000000);
    check("reg OVF OVF_Q", {31'b0, OVF_Q}, 32'h1);

    @(negedge clk);
    apply(4'b0110, 32'h1234, 32'h5678);
    @(posedge clk); #1;
    check("reg undef RES_Q", RES_Q, 32'h0);
    check("reg undef ZERO_Q", {31'b0, ZERO_Q}, 32'h1);

    // Mid-cycle async reset: registers clear at once, combinational path untouched.
    @(negedge clk);
    apply(OP_ADD, 32'd2, 32'd3);
    @(posedge clk); #1;
    check("pre-reset RES_Q", RES_Q, 32'd5);
    #20 rst_n = 1'b0;
    #1;
    check("async reset RES_Q", RES_Q, 32'h0);
    check("async reset ZERO_Q", {31'b0, ZERO_Q}, 32'h0);
    check("RES during reset", RES, 32'd5);
    check("ZERO during reset", {31'b0, ZERO}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- directed vector table ----
    foreach (vecs[i]) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      #60;
      check($sformatf("vec%0d op=%b RES", i, vecs[i].op), RES, vecs[i].res);
      check($sformatf("vec%0d op=%b ZERO", i, vecs[i].op), {31'b0, ZERO},
            {31'b0, vecs[i].zero});
      check($sformatf("vec%0d op=%b OVF", i, vecs[i].op), {31'b0, OVF},
            {31'b0, vecs[i].ovf});
      #40;
    end

    // ---- random sweep against the reference model ----
    for (int i = 0; i < 100; i++) begin
      logic [3:0]  o;
      logic [31:0] a, b;
      o = ops[$urandom_range(0, 6)];
      a = $urandom;
      b = $urandom;
      // Occasionally force extremes so overflow and SLT corners are exercised.
      if (i % 10 == 0) a = 32'h80000000;
      if (i % 10 == 5) b = 32'h7FFFFFFF;
      apply(o, a, b);
      model(o, a, b, exp_r, exp_v);
      #80;
      check($sformatf("rnd%0d op=%b RES", i, o), RES, exp_r);
      check($sformatf("rnd%0d op=%b ZERO", i, o), {31'b0, ZERO},
            {31'b0, (exp_r == 32'h0)});
      check($sformatf("rnd%0d op=%b OVF", i, o), {31'b0, OVF}, {31'b0, exp_v});
      #20;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

32-bit combinational arithmetic/logic unit for the single-cycle MIPS datapath. It computes RES from operands A and B under a 4-bit opcode and flags a zero result for branch decisions. A registered copy of the result and flags is provided for pipelined or debug consumers.

## Interface
Parameters:
- WIDTH, 32, operand and result width.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; only the registered outputs use it.
- rst_n  in  1  asynchronous active-low reset; clears the registered outputs only.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- op  in  4  operation select.
- RES  out  WIDTH  combinational result.
- ZERO  out  1  combinational; 1 iff RES == 0.
- OVF  out  1  combinational signed overflow; meaningful for ADD/SUB only, 0 otherwise.
- RES_Q  out  WIDTH  RES registered on the rising clk edge.
- ZERO_Q  out  1  ZERO registered on the rising clk edge.
- OVF_Q  out  1  OVF registered on the rising clk edge.

## Operation
Opcode map:
- 0000 AND: A & B.
- 0001 OR: A | B.
- 0010 ADD: A + B, modulo 2^WIDTH.
- 1010 SUB: A − B, computed as A + ~B + 1, modulo 2^WIDTH.
- 0100 XOR: A ^ B.
- 0101 NOR: ~(A | B).
- 1011 SLT: RES = {31'b0, 1} if signed(A) < signed(B), else 0.
  - The comparison is the sign of (A − B) XOR the subtract overflow, so it is correct at the extremes.
- Any other opcode: RES = 0, so ZERO = 1.

Rules:
- OVF for ADD = (A[31] == B[31]) && (RES[31] != A[31]).
- OVF for SUB = (A[31] != B[31]) && (RES[31] != A[31]).
- Carry-out is discarded.
- No X propagation from unused opcodes; every output is fully defined for every defined input.

## Timing
- RES, ZERO and OVF are purely combinational: zero-cycle latency, valid within the same cycle the inputs change. The verification bench samples 60 ns after applying inputs.
- RES_Q, ZERO_Q and OVF_Q take the combinational values at each rising clk edge; latency is 1 cycle.
- rst_n low, asserted at any time: RES_Q = 0, ZERO_Q = 0, OVF_Q = 0 immediately, without waiting for a clock edge.
- Reset never affects the combinational outputs.
- Release of rst_n: the registers load normally on the first rising edge with rst_n high.
- No handshake and no internal state other than the three output registers.

## Structure
- Shared package alu_pkg holds:
  - the opcode localparams: OP_AND, OP_OR, OP_ADD, OP_SUB, OP_XOR, OP_NOR, OP_SLT;
  - WIDTH_DEFAULT = 32.
- One sub-module, alu_addsub, is natural. It is a WIDTH-bit adder with an invert-B/carry-in control and produces sum and overflow, shared by ADD, SUB and SLT.
- Result selection is a single case on op in the top module, followed by the output register process.

## Test plan
- Logic ops: A=F0F0F0F0, B=FF00FF00.
  - op 0000 -> RES=F000F000, ZERO=0.
  - op 0001 -> RES=FFF0FFF0.
  - op 0100 -> RES=0FF00FF0.
  - op 0101 -> RES=000F000F.
- Add/sub wrap:
  - ADD A=FFFFFFFF, B=00000001 -> RES=0, ZERO=1, OVF=0.
  - ADD A=7FFFFFFF, B=1 -> RES=80000000, OVF=1.
  - SUB A=80000000, B=1 -> RES=7FFFFFFF, OVF=1.
- SLT signed:
  - A=FFFFFFFF, B=1 -> RES=1.
  - A=1, B=FFFFFFFF -> RES=0, ZERO=1.
  - A=80000000, B=7FFFFFFF -> RES=1.
  - A=B=5 -> RES=0.
- Undefined opcodes: op 0011, 0110, 1111 with A=1234, B=5678 -> RES=0, ZERO=1, OVF=0.
- Registered path: apply ADD 2+3, then one clk edge -> RES_Q=5, ZERO_Q=0. Then assert rst_n=0 mid-cycle -> RES_Q=0 with no clock edge; RES still 5.
- Sweep: 100 random vectors over all defined opcodes, compared against a reference model. Check RES and ZERO at 80 ns into each 100 ns cycle; expect zero errors.
